// File: rtl/debug_arbiter.sv
// Two-master round-robin arbiter in front of a single debug slave, one transaction outstanding.
// Optional response timeout is compiled in when DEBUG_ARB_TIMEOUT_EN is defined.
module debug_arbiter #(
    parameter int unsigned ADDR_WIDTH     = 15,
    parameter int unsigned DATA_WIDTH     = 65,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  m0_req_i,
    input  logic [ADDR_WIDTH-1:0] m0_addr_i,
    input  logic                  m0_we_i,
    input  logic [DATA_WIDTH-1:0] m0_wdata_i,
    output logic                  m0_gnt_o,
    output logic                  m0_rvalid_o,
    output logic [DATA_WIDTH-1:0] m0_rdata_o,
    input  logic                  m1_req_i,
    input  logic [ADDR_WIDTH-1:0] m1_addr_i,
    input  logic                  m1_we_i,
    input  logic [DATA_WIDTH-1:0] m1_wdata_i,
    output logic                  m1_gnt_o,
    output logic                  m1_rvalid_o,
    output logic [DATA_WIDTH-1:0] m1_rdata_o,
    output logic                  s_req_o,
    output logic [ADDR_WIDTH-1:0] s_addr_o,
    output logic                  s_we_o,
    output logic [DATA_WIDTH-1:0] s_wdata_o,
    input  logic                  s_gnt_i,
    input  logic                  s_rvalid_i,
    input  logic [DATA_WIDTH-1:0] s_rdata_i,
    output logic                  timeout_o
);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        WAIT_GNT    = 2'd1,
        WAIT_RVALID = 2'd2
    } state_e;

    state_e state_q, state_d;
    logic   owner_q, owner_d;
    logic   ptr_q, ptr_d;

    logic                  any_req;
    logic                  win;
    logic                  sel;
    logic                  req_active;
    logic                  tmo;
    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_data;

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("debug_arbiter: TIMEOUT_CYCLES must be within 2..255");
    end

`ifdef DEBUG_ARB_TIMEOUT_EN
    localparam int unsigned CntWidth = 8;
    logic [CntWidth-1:0] cnt_q, cnt_d;
`endif

    // Winner selection and response muxing; the owner is live-arbitrated only in IDLE
    always_comb begin
        any_req    = m0_req_i | m1_req_i;
        win        = (m0_req_i & m1_req_i) ? ptr_q : m1_req_i;
        sel        = (state_q == IDLE) ? win : owner_q;
        req_active = ((state_q == IDLE) & any_req) | (state_q == WAIT_GNT);
`ifdef DEBUG_ARB_TIMEOUT_EN
        tmo        = (state_q == WAIT_RVALID) & ~s_rvalid_i
                     & (cnt_q == CntWidth'(TIMEOUT_CYCLES));
`else
        tmo        = 1'b0;
`endif
        rsp_valid  = (state_q == WAIT_RVALID) & (s_rvalid_i | tmo);
        rsp_data   = s_rvalid_i ? s_rdata_i : {DATA_WIDTH{1'b1}};
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
`ifdef DEBUG_ARB_TIMEOUT_EN
        cnt_d   = ((state_q == WAIT_RVALID) && !rsp_valid) ? cnt_q + CntWidth'(1) : '0;
`endif
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    owner_d = win;
                    if (s_gnt_i) begin
                        state_d = WAIT_RVALID;
                        ptr_d   = ~win;
                    end else begin
                        state_d = WAIT_GNT;
                    end
                end
            end
            WAIT_GNT: begin
                if (s_gnt_i) begin
                    state_d = WAIT_RVALID;
                    ptr_d   = ~owner_q;
                end
            end
            WAIT_RVALID: begin
                if (rsp_valid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            ptr_q   <= 1'b0;
`ifdef DEBUG_ARB_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
`ifdef DEBUG_ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    // Outputs are forced low while reset is held
    always_comb begin
        s_req_o     = rst_ni & req_active;
        s_addr_o    = s_req_o ? (sel ? m1_addr_i  : m0_addr_i)  : '0;
        s_we_o      = s_req_o & (sel ? m1_we_i : m0_we_i);
        s_wdata_o   = s_req_o ? (sel ? m1_wdata_i : m0_wdata_i) : '0;
        m0_gnt_o    = s_req_o & s_gnt_i & ~sel;
        m1_gnt_o    = s_req_o & s_gnt_i & sel;
        m0_rvalid_o = rst_ni & rsp_valid & ~owner_q;
        m1_rvalid_o = rst_ni & rsp_valid & owner_q;
        m0_rdata_o  = m0_rvalid_o ? rsp_data : '0;
        m1_rdata_o  = m1_rvalid_o ? rsp_data : '0;
        timeout_o   = rst_ni & tmo;
    end

endmodule

// File: tb/tb_debug_arbiter.sv
// Directed self-checking bench for debug_arbiter; timeout section follows DEBUG_ARB_TIMEOUT_EN.
module tb_debug_arbiter;
    localparam int unsigned AW = 15;
    localparam int unsigned DW = 65;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          m0_req_i, m0_we_i, m1_req_i, m1_we_i;
    logic [AW-1:0] m0_addr_i, m1_addr_i;
    logic [DW-1:0] m0_wdata_i, m1_wdata_i;
    logic          m0_gnt_o, m0_rvalid_o, m1_gnt_o, m1_rvalid_o;
    logic [DW-1:0] m0_rdata_o, m1_rdata_o;
    logic          s_req_o, s_we_o, s_gnt_i, s_rvalid_i, timeout_o;
    logic [AW-1:0] s_addr_o;
    logic [DW-1:0] s_wdata_o, s_rdata_i;

    int n_checks = 0;
    int n_fail   = 0;

    debug_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(16)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .m0_req_i(m0_req_i), .m0_addr_i(m0_addr_i), .m0_we_i(m0_we_i), .m0_wdata_i(m0_wdata_i),
        .m0_gnt_o(m0_gnt_o), .m0_rvalid_o(m0_rvalid_o), .m0_rdata_o(m0_rdata_o),
        .m1_req_i(m1_req_i), .m1_addr_i(m1_addr_i), .m1_we_i(m1_we_i), .m1_wdata_i(m1_wdata_i),
        .m1_gnt_o(m1_gnt_o), .m1_rvalid_o(m1_rvalid_o), .m1_rdata_o(m1_rdata_o),
        .s_req_o(s_req_o), .s_addr_o(s_addr_o), .s_we_o(s_we_o), .s_wdata_o(s_wdata_o),
        .s_gnt_i(s_gnt_i), .s_rvalid_i(s_rvalid_i), .s_rdata_i(s_rdata_i),
        .timeout_o(timeout_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        @(negedge clk_i);
    endtask

    task automatic idle_inputs();
        m0_req_i = 1'b0; m0_we_i = 1'b0; m0_addr_i = '0; m0_wdata_i = '0;
        m1_req_i = 1'b0; m1_we_i = 1'b0; m1_addr_i = '0; m1_wdata_i = '0;
        s_gnt_i = 1'b0; s_rvalid_i = 1'b0; s_rdata_i = '0;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        tick();
        tick();
        rst_ni = 1'b1;
    endtask

    // Request with immediate grant, response one cycle later
    task automatic one_shot(input logic r0, input logic r1, input logic exp_m1,
                            input logic [DW-1:0] data, input string tag);
        m0_req_i = r0; m1_req_i = r1; s_gnt_i = 1'b1;
        settle();
        check({tag, "_gnt0"}, DW'(m0_gnt_o), DW'(!exp_m1));
        check({tag, "_gnt1"}, DW'(m1_gnt_o), DW'(exp_m1));
        tick();
        m0_req_i = 1'b0; m1_req_i = 1'b0; s_gnt_i = 1'b0;
        s_rvalid_i = 1'b1; s_rdata_i = data;
        settle();
        check({tag, "_rv0"}, DW'(m0_rvalid_o), DW'(!exp_m1));
        check({tag, "_rv1"}, DW'(m1_rvalid_o), DW'(exp_m1));
        check({tag, "_rdata"}, exp_m1 ? m1_rdata_o : m0_rdata_o, data);
        check({tag, "_rdata_other"}, exp_m1 ? m0_rdata_o : m1_rdata_o, '0);
        tick();
        s_rvalid_i = 1'b0;
    endtask

    initial begin
        rst_ni = 1'b0;
        idle_inputs();
        m0_req_i = 1'b1; m0_addr_i = 15'h7FFF; s_gnt_i = 1'b1;
        settle();
        check("rst_s_req", DW'(s_req_o), '0);
        check("rst_s_addr", DW'(s_addr_o), '0);
        check("rst_m0_gnt", DW'(m0_gnt_o), '0);
        check("rst_timeout", DW'(timeout_o), '0);
        tick();
        rst_ni = 1'b1;
        idle_inputs();

        // Single m0 read, granted immediately
        m0_req_i = 1'b1; m0_addr_i = 15'h0010; s_gnt_i = 1'b1;
        settle();
        check("single_s_req", DW'(s_req_o), DW'(1));
        check("single_s_addr", DW'(s_addr_o), DW'(16'h0010));
        check("single_s_we", DW'(s_we_o), '0);
        check("single_gnt0", DW'(m0_gnt_o), DW'(1));
        check("single_gnt1", DW'(m1_gnt_o), '0);
        tick();
        m0_req_i = 1'b0; s_gnt_i = 1'b0; s_rvalid_i = 1'b1; s_rdata_i = 65'h1_2345_6789;
        settle();
        check("single_s_req_wait", DW'(s_req_o), '0);
        check("single_rv0", DW'(m0_rvalid_o), DW'(1));
        check("single_rdata0", m0_rdata_o, 65'h1_2345_6789);
        check("single_rv1", DW'(m1_rvalid_o), '0);
        check("single_rdata1", m1_rdata_o, '0);
        tick();
        s_rvalid_i = 1'b0;

        // Round robin out of reset
        do_reset();
        one_shot(1'b1, 1'b1, 1'b0, 65'hA0, "rr0");
        one_shot(1'b1, 1'b1, 1'b1, 65'hA1, "rr1");
        one_shot(1'b1, 1'b1, 1'b0, 65'hA2, "rr2");

        // Grant stall with competing m1; m0 drops its request mid-wait
        m0_req_i = 1'b1; m0_addr_i = 15'h0AAA; m1_addr_i = 15'h1555; s_gnt_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            if (c == 1) m1_req_i = 1'b1;
            if (c == 2) m0_req_i = 1'b0;
            settle();
            check("stall_s_req", DW'(s_req_o), DW'(1));
            check("stall_s_addr", DW'(s_addr_o), DW'(16'h0AAA));
            check("stall_gnt1", DW'(m1_gnt_o), '0);
            tick();
        end
        s_gnt_i = 1'b1;
        settle();
        check("stall_gnt0", DW'(m0_gnt_o), DW'(1));
        check("stall_gnt1_late", DW'(m1_gnt_o), '0);
        check("stall_s_addr_gnt", DW'(s_addr_o), DW'(16'h0AAA));
        tick();
        s_gnt_i = 1'b0; s_rvalid_i = 1'b1; s_rdata_i = 65'h5A;
        settle();
        check("stall_rv0", DW'(m0_rvalid_o), DW'(1));
        check("stall_rv1", DW'(m1_rvalid_o), '0);
        check("stall_s_req_wait", DW'(s_req_o), '0);
        tick();
        s_rvalid_i = 1'b0; s_gnt_i = 1'b1;
        settle();
        check("turn_s_addr", DW'(s_addr_o), DW'(16'h1555));
        check("turn_gnt1", DW'(m1_gnt_o), DW'(1));
        tick();
        s_gnt_i = 1'b0; s_rvalid_i = 1'b1; s_rdata_i = 65'h77;
        settle();
        check("turn_rv1", DW'(m1_rvalid_o), DW'(1));
        check("turn_rdata1", m1_rdata_o, 65'h77);
        check("turn_rv0", DW'(m0_rvalid_o), '0);
        tick();
        m1_req_i = 1'b0; s_rvalid_i = 1'b0;

        // Spurious response in IDLE
        s_rvalid_i = 1'b1; s_rdata_i = 65'hDEAD;
        settle();
        check("spur_rv0", DW'(m0_rvalid_o), '0);
        check("spur_rv1", DW'(m1_rvalid_o), '0);
        check("spur_rdata0", m0_rdata_o, '0);
        tick();
        s_rvalid_i = 1'b0;
        one_shot(1'b1, 1'b1, 1'b0, 65'h1234, "post_spur");

        // Reset in WAIT_RVALID with pointer at m1, then a late response
        m0_req_i = 1'b1; s_gnt_i = 1'b1;
        settle();
        check("rstmid_gnt0", DW'(m0_gnt_o), DW'(1));
        tick();
        idle_inputs();
        settle();
        check("rstmid_s_req_wait", DW'(s_req_o), '0);
        rst_ni = 1'b0;
        #1;
        check("rstmid_rv0_inrst", DW'(m0_rvalid_o), '0);
        tick();
        tick();
        rst_ni = 1'b1;
        s_rvalid_i = 1'b1; s_rdata_i = 65'hBEEF;
        settle();
        check("rstmid_late_rv0", DW'(m0_rvalid_o), '0);
        check("rstmid_late_rv1", DW'(m1_rvalid_o), '0);
        tick();
        s_rvalid_i = 1'b0;
        one_shot(1'b1, 1'b1, 1'b0, 65'h99, "rstmid_ptr");

`ifdef DEBUG_ARB_TIMEOUT_EN
        // No response: timeout 16 cycles after entering WAIT_RVALID
        m0_req_i = 1'b1; s_gnt_i = 1'b1;
        tick();
        idle_inputs();
        for (int k = 0; k < 16; k++) begin
            settle();
            check("tmo_early_pulse", DW'(timeout_o), '0);
            check("tmo_early_rv0", DW'(m0_rvalid_o), '0);
            tick();
        end
        settle();
        check("tmo_pulse", DW'(timeout_o), DW'(1));
        check("tmo_rv0", DW'(m0_rvalid_o), DW'(1));
        check("tmo_rdata0", m0_rdata_o, {DW{1'b1}});
        check("tmo_rv1", DW'(m1_rvalid_o), '0);
        tick();
        settle();
        check("tmo_pulse_end", DW'(timeout_o), '0);
        check("tmo_rv0_end", DW'(m0_rvalid_o), '0);
        tick();
`else
        // No timeout: WAIT_RVALID holds until the slave answers
        m0_req_i = 1'b1; s_gnt_i = 1'b1;
        tick();
        idle_inputs();
        for (int k = 0; k < 20; k++) begin
            settle();
            check("notmo_pulse", DW'(timeout_o), '0);
            check("notmo_rv0", DW'(m0_rvalid_o), '0);
            tick();
        end
        s_rvalid_i = 1'b1; s_rdata_i = 65'h42;
        settle();
        check("notmo_rv0_final", DW'(m0_rvalid_o), DW'(1));
        check("notmo_rdata0", m0_rdata_o, 65'h42);
        tick();
        s_rvalid_i = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
